// File: rtl/i2s_tx_serializer_if.sv
// Sample-pair handshake between the equalizer datapath and the I2S transmitter.
interface i2s_tx_serializer_if #(
    parameter int SAMPLE_W = 16
);
    logic signed [SAMPLE_W-1:0] lft_in;
    logic signed [SAMPLE_W-1:0] rht_in;
    logic                       in_vld;
    logic                       in_rdy;

    modport master (
        output lft_in,
        output rht_in,
        output in_vld,
        input  in_rdy
    );

    modport slave (
        input  lft_in,
        input  rht_in,
        input  in_vld,
        output in_rdy
    );
endinterface

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: derives MCLK/SCLK/LRCLK from a free-running 10-bit counter
// and shifts one left/right pair per 1024-clock frame MSB-first onto SDin,
// left-justified in 24-bit slots with the I2S one-bit delay.
module i2s_tx_serializer #(
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    i2s_tx_serializer_if.slave    s_if,
    output logic                  MCLK,
    output logic                  SCLK,
    output logic                  LRCLK,
    output logic                  SDin,
    output logic                  frm_strt,
    output logic                  underrun
);
    localparam int PAD_W = SLOT_W - SAMPLE_W;

    logic [9:0]                 cnt;
    logic [9:0]                 cnt_nxt;
    logic                       frame_load;
    logic                       buf_full;
    logic signed [SAMPLE_W-1:0] buf_lft;
    logic signed [SAMPLE_W-1:0] buf_rht;
    logic signed [SLOT_W-1:0]   lft_sr;
    logic signed [SLOT_W-1:0]   rht_sr;
    logic                       sd;

    // Bit presented in a given slot: slot 0 is the I2S delay bit, slots
    // 1..SLOT_W carry the word MSB first, anything after that is zero.
    function automatic logic slot_bit(input logic signed [SLOT_W-1:0] word,
                                      input logic [4:0] slot);
        logic              bit_val;
        logic [SLOT_W-1:0] sh;
        bit_val = 1'b0;
        sh      = '0;
        if (slot != 5'd0 && int'(slot) <= SLOT_W) begin
            sh      = word >> (SLOT_W - int'(slot));
            bit_val = sh[0];
        end
        return bit_val;
    endfunction

    assign cnt_nxt     = cnt + 10'd1;
    assign frame_load  = (cnt == 10'h3FF);
    assign MCLK        = cnt[1];
    assign SCLK        = cnt[3];
    assign LRCLK       = cnt[9];
    assign SDin        = sd;
    assign s_if.in_rdy = ~buf_full;

    // Free-running frame timing counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Holding buffer capture and frame load: buffered pair first, then a
    // same-cycle bypass, otherwise the shift registers keep the last pair
    // and are retransmitted as-is.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full <= 1'b0;
            buf_lft  <= '0;
            buf_rht  <= '0;
            lft_sr   <= '0;
            rht_sr   <= '0;
            frm_strt <= 1'b0;
            underrun <= 1'b0;
        end else begin
            frm_strt <= 1'b0;
            underrun <= 1'b0;
            if (frame_load) begin
                if (buf_full) begin
                    lft_sr   <= {buf_lft, {PAD_W{1'b0}}};
                    rht_sr   <= {buf_rht, {PAD_W{1'b0}}};
                    buf_full <= 1'b0;
                    frm_strt <= 1'b1;
                end else if (s_if.in_vld) begin
                    lft_sr   <= {s_if.lft_in, {PAD_W{1'b0}}};
                    rht_sr   <= {s_if.rht_in, {PAD_W{1'b0}}};
                    frm_strt <= 1'b1;
                end else begin
                    underrun <= 1'b1;
                end
            end else if (s_if.in_vld && !buf_full) begin
                buf_lft  <= s_if.lft_in;
                buf_rht  <= s_if.rht_in;
                buf_full <= 1'b1;
            end
        end
    end

    // Serial data changes with the SCLK falling edge for the upcoming slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            sd <= 1'b0;
        end else if (cnt[3:0] == 4'hF) begin
            sd <= slot_bit(cnt_nxt[9] ? rht_sr : lft_sr, cnt_nxt[8:4]);
        end
    end
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for the I2S transmitter: clock generation, frame contents,
// underrun repeat, bypass load, back-to-back handshake and mid-frame reset.
module tb_i2s_tx_serializer;
    logic clk;
    logic rst;
    logic mclk;
    logic sclk;
    logic lrclk;
    logic sdin;
    logic frm_strt;
    logic underrun;
    logic [9:0] mcnt;
    int checks;
    int errors;

    i2s_tx_serializer_if #(.SAMPLE_W(16)) bus ();

    i2s_tx_serializer #(.SAMPLE_W(16), .SLOT_W(24)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_if     (bus),
        .MCLK     (mclk),
        .SCLK     (sclk),
        .LRCLK    (lrclk),
        .SDin     (sdin),
        .frm_strt (frm_strt),
        .underrun (underrun)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference frame position: cleared by reset, otherwise counts and wraps.
    always @(posedge clk) begin
        if (rst) mcnt <= 10'd0;
        else     mcnt <= mcnt + 10'd1;
    end

    task automatic wait_cnt(input logic [9:0] target);
        int n;
        n = 0;
        while (mcnt !== target && n < 2048) begin
            @(negedge clk);
            n++;
        end
        if (mcnt !== target) begin
            checks++;
            errors++;
            $display("FAIL wait_cnt: reached %0d, required %0d", mcnt, target);
        end
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r,
                        output logic [9:0] acc_cnt);
        int   n;
        logic ok;
        n = 0;
        ok = 1'b0;
        acc_cnt = '0;
        bus.lft_in = l;
        bus.rht_in = r;
        bus.in_vld = 1'b1;
        while (!ok && n < 4096) begin
            if (bus.in_rdy === 1'b1) begin
                ok = 1'b1;
                acc_cnt = mcnt;
            end
            @(negedge clk);
            n++;
        end
        bus.in_vld = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_rdy never 1 for pair %h/%h", l, r);
        end
    endtask

    // Starts at the negedge where mcnt==0 and ends at mcnt==0 of the next frame.
    task automatic capture_frame(output logic [23:0] l, output logic [23:0] r,
                                 output int pad_err, output logic fs0,
                                 output logic ur0, output logic pulse1);
        int slot;
        l = '0;
        r = '0;
        pad_err = 0;
        fs0 = frm_strt;
        ur0 = underrun;
        pulse1 = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            if (i == 1) pulse1 = frm_strt | underrun;
            if (mcnt[3:0] == 4'd8) begin
                slot = int'(mcnt[8:4]);
                if (slot >= 1 && slot <= 24) begin
                    if (mcnt[9]) r = {r[22:0], sdin};
                    else         l = {l[22:0], sdin};
                end else if (sdin !== 1'b0) begin
                    pad_err++;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string name, input logic [23:0] exp_l,
                               input logic [23:0] exp_r, input logic exp_fs,
                               input logic exp_ur);
        logic [23:0] l;
        logic [23:0] r;
        int          pad_err;
        logic        fs0;
        logic        ur0;
        logic        pulse1;
        capture_frame(l, r, pad_err, fs0, ur0, pulse1);
        checks++;
        if (l !== exp_l) begin
            errors++;
            $display("FAIL %s_left: got %h, required %h", name, l, exp_l);
        end
        checks++;
        if (r !== exp_r) begin
            errors++;
            $display("FAIL %s_right: got %h, required %h", name, r, exp_r);
        end
        checks++;
        if (pad_err !== 0) begin
            errors++;
            $display("FAIL %s_pad: %0d nonzero pad slots, required 0", name, pad_err);
        end
        checks++;
        if (fs0 !== exp_fs) begin
            errors++;
            $display("FAIL %s_frm_strt: got %b, required %b", name, fs0, exp_fs);
        end
        checks++;
        if (ur0 !== exp_ur) begin
            errors++;
            $display("FAIL %s_underrun: got %b, required %b", name, ur0, exp_ur);
        end
        checks++;
        if (pulse1 !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse_width: pulse still high at cnt=1, required 0", name);
        end
    endtask

    task automatic test_reset();
        int e_mclk, e_sclk, e_lrclk, e_sd, e_pulse, e_rdy;
        logic [9:0] k;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mclk, sclk, lrclk, sdin, frm_strt, underrun} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 000000",
                     {mclk, sclk, lrclk, sdin, frm_strt, underrun});
        end
        checks++;
        if (bus.in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_rdy: got %b, required 1", bus.in_rdy);
        end
        rst = 1'b0;
        e_mclk = 0; e_sclk = 0; e_lrclk = 0; e_sd = 0; e_pulse = 0; e_rdy = 0;
        for (int i = 0; i < 1023; i++) begin
            k = 10'(i);
            if (mclk !== k[1]) e_mclk++;
            if (sclk !== k[3]) e_sclk++;
            if (lrclk !== (i >= 512)) e_lrclk++;
            if (sdin !== 1'b0) e_sd++;
            if (frm_strt !== 1'b0 || underrun !== 1'b0) e_pulse++;
            if (bus.in_rdy !== 1'b1) e_rdy++;
            @(negedge clk);
        end
        checks++;
        if (e_mclk !== 0) begin errors++; $display("FAIL mclk_period: %0d bad cycles, required 0", e_mclk); end
        checks++;
        if (e_sclk !== 0) begin errors++; $display("FAIL sclk_period: %0d bad cycles, required 0", e_sclk); end
        checks++;
        if (e_lrclk !== 0) begin errors++; $display("FAIL lrclk_period: %0d bad cycles, required 0", e_lrclk); end
        checks++;
        if (e_sd !== 0) begin errors++; $display("FAIL idle_sdin: %0d nonzero cycles, required 0", e_sd); end
        checks++;
        if (e_pulse !== 0) begin errors++; $display("FAIL early_pulse: %0d pulse cycles, required 0", e_pulse); end
        checks++;
        if (e_rdy !== 0) begin errors++; $display("FAIL idle_in_rdy: %0d low cycles, required 0", e_rdy); end
    endtask

    task automatic test_basic_frame();
        logic [9:0] acc;
        wait_cnt(10'd100);
        push(16'h8001, 16'h7FFE, acc);
        checks++;
        if (bus.in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL basic_in_rdy_drop: got %b, required 0", bus.in_rdy);
        end
        wait_cnt(10'd0);
        checks++;
        if (bus.in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL basic_in_rdy_after_load: got %b, required 1", bus.in_rdy);
        end
        check_frame("basic", 24'h800100, 24'h7FFE00, 1'b1, 1'b0);
    endtask

    task automatic test_underrun();
        check_frame("underrun", 24'h800100, 24'h7FFE00, 1'b0, 1'b1);
    endtask

    task automatic test_bypass();
        wait_cnt(10'd1023);
        checks++;
        if (bus.in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bypass_in_rdy_before: got %b, required 1", bus.in_rdy);
        end
        bus.lft_in = 16'h1234;
        bus.rht_in = 16'hABCD;
        bus.in_vld = 1'b1;
        @(negedge clk);
        bus.in_vld = 1'b0;
        checks++;
        if (bus.in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bypass_in_rdy_after: got %b, required 1", bus.in_rdy);
        end
        check_frame("bypass", 24'h123400, 24'hABCD00, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [9:0] acc_a;
        logic [9:0] acc_b;
        push(16'h0F0F, 16'hF0F0, acc_a);
        checks++;
        if (bus.in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_in_rdy_drop: got %b, required 0", bus.in_rdy);
        end
        fork
            push(16'h5A5A, 16'hA5A5, acc_b);
            begin
                wait_cnt(10'd0);
                check_frame("b2b_first", 24'h0F0F00, 24'hF0F000, 1'b1, 1'b0);
                check_frame("b2b_second", 24'h5A5A00, 24'hA5A500, 1'b1, 1'b0);
            end
        join
        checks++;
        if (acc_b !== 10'd0) begin
            errors++;
            $display("FAIL b2b_accept_cycle: accepted after cnt=%0d, required 0", acc_b);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] acc;
        wait_cnt(10'd300);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mclk, sclk, lrclk, sdin, frm_strt, underrun} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got %b, required 000000",
                     {mclk, sclk, lrclk, sdin, frm_strt, underrun});
        end
        checks++;
        if (bus.in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_rdy: got %b, required 1", bus.in_rdy);
        end
        rst = 1'b0;
        check_frame("midrst_abort", 24'h000000, 24'h000000, 1'b0, 1'b0);
        check_frame("midrst_underrun", 24'h000000, 24'h000000, 1'b0, 1'b1);
        push(16'h0001, 16'hFFFF, acc);
        wait_cnt(10'd0);
        check_frame("midrst_new", 24'h000100, 24'hFFFF00, 1'b1, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.lft_in = '0;
        bus.rht_in = '0;
        bus.in_vld = 1'b0;
        test_reset();
        test_basic_frame();
        test_underrun();
        test_bypass();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Codec-facing I2S transmitter for the equalizer datapath; the transmit counterpart of the I2S receiver that deserializes codec SDout.
- Accepts processed 16-bit left/right sample pairs over a valid/ready handshake, generates MCLK/SCLK/LRCLK from the 50 MHz system clock, and shifts each pair MSB-first onto SDin.
- Each word is sent as a 24-bit left-justified I2S word, one bit delayed from LRCLK.
- Fs = 50 MHz / 1024 ≈ 48828 Hz.

Parameters:
- SAMPLE_W, 16, width of input samples.
- SLOT_W, 24, serialized word width; input is left-justified, low (SLOT_W-SAMPLE_W) bits are zero.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- lft_in  in  16  signed left sample.
- rht_in  in  16  signed right sample.
- in_vld  in  1  sample pair valid.
- in_rdy  out  1  holding buffer empty, pair accepted when in_vld & in_rdy.
- MCLK  out  1  clk/4 (256·Fs).
- SCLK  out  1  clk/16 (64·Fs).
- LRCLK  out  1  low = left half-frame, high = right half-frame.
- SDin  out  1  serial data to the codec.
- frm_strt  out  1  one-cycle pulse when a new pair is loaded for transmission.
- underrun  out  1  one-cycle pulse when a frame starts with no pair available.

Behaviour:
- Timing counter:
  - 10-bit free-running cnt, wraps 1023→0.
  - MCLK = cnt[1], SCLK = cnt[3], LRCLK = cnt[9].
  - SCLK falls when cnt[3:0] wraps 15→0 and rises at cnt[3:0]=8.
  - Bit slot within the half-frame = cnt[8:4] (0..31).
- Reset:
  - cnt=0; MCLK=SCLK=LRCLK=0; SDin=0; frm_strt=0; underrun=0.
  - Holding buffer empty, so in_rdy=1.
  - Shift registers and last-pair register = 0.
  - A reset asserted mid-frame aborts the frame immediately; no partial word is resumed.
- Handshake:
  - in_rdy = ~buf_full.
  - On in_vld & in_rdy the pair is captured into the holding buffer and buf_full is set.
- Frame load (cycle where cnt=1023), evaluated in priority order:
  - (a) buf_full: load {lft,8'h00} and {rht,8'h00} into the left/right shift registers, clear buf_full, pulse frm_strt next cycle.
  - (b) Buffer empty and in_vld: bypass the incoming pair directly into the shift registers. The buffer stays empty, in_rdy stays 1, frm_strt pulses, no underrun.
  - (c) Otherwise: reload the last transmitted pair (repeat-last policy) and pulse underrun next cycle. frm_strt does not pulse.
- Buffer full at cnt=1023: a new pair is not accepted that cycle, because in_rdy=0. The next in_vld is accepted the cycle after the load.
- SDin update:
  - Registered, updated when cnt[3:0]=15, so it transitions coincident with the SCLK falling edge and is stable at the SCLK rise.
  - The value presented for slot s = next cnt[8:4] within the half-frame selected by next cnt[9].
  - Slot 0 → 0 (I2S one-bit delay).
  - Slots 1..24 → word bit (24-s), MSB first.
  - Slots 25..31 → 0.
- Latency:
  - Left MSB appears on SDin 16 clk after the frame load (slot 1, cnt=16).
  - Right MSB appears at cnt=528.
- Two's-complement data is passed unmodified; no saturation, no sign extension into the pad bits.
- At most one pair is held plus one pair in flight; there is no deeper FIFO.

Test Plan:
- Reset release → MCLK period 4 clk, SCLK period 16 clk, LRCLK period 1024 clk with low for the first 512; SDin=0, in_rdy=1, no pulses before the first cnt=1023.
- Push lft=16'h8001, rht=16'h7FFE before the first frame → frm_strt at cnt=0. Sampling SDin at SCLK rises reads left slots 1..24 = 0x800100 and right slots 1..24 = 0x7FFE00, with slot 0 and slots 25..31 zero.
- Hold in_vld low after one pair → the next frame raises underrun at cnt=0 and retransmits 0x800100/0x7FFE00; frm_strt stays low.
- Assert in_vld with buffer empty exactly at cnt=1023 → bypass: frm_strt pulses, no underrun, in_rdy stays 1.
- Two back-to-back pairs → first accepted and in_rdy drops; second held until the cycle after the cnt=1023 load, then accepted; both transmitted in order on consecutive frames.
- Assert rst at cnt=300 mid-word → next cycle all outputs 0 and cnt=0; the following frame transmits zeros with underrun, or new data if a pair is pushed.
